mips_multicycle_datapath: RTL and testbench

- Multicycle MIPS datapath, the consumer of the existing control unit's outputs.
- Holds PC, instruction register, memory data register, A/B operand registers, ALUOut register, 32-entry register file and the ALU.
- Returns op, funct and ZeroFlag to the controller.
- Drives a single unified instruction/data memory port with combinational read and synchronous write; the memory itself is outside this block.

---
 rtl/mips_multicycle_datapath.sv | 125 ++++++++++++
 tb/tb_mips_multicycle_datapath.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, 32x register file and ALU.
// The controller supplies every select/enable; memory sits outside on a single port.
module mips_multicycle_datapath #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IorD,
  input  logic             MemWrite,
  input  logic             IRWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [2:0]       ALUcontrol,
  input  logic [1:0]       PCSrc,
  input  logic             PCEn,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  output logic             MemWriteOut,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             ZeroFlag
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] aluout_q;
  logic [WIDTH-1:0] rf_q [32];

  logic [4:0]       rs_addr, rt_addr, rd_addr, wr_addr;
  logic [WIDTH-1:0] rd1, rd2, wr_data;
  logic [WIDTH-1:0] sign_imm, src_a, src_b, alu_result, jump_target;

  assign rs_addr = ir_q[25:21];
  assign rt_addr = ir_q[20:16];
  assign rd_addr = ir_q[15:11];

  // Entry 0 is never written, so it reads zero without a special case.
  assign rd1 = rf_q[rs_addr];
  assign rd2 = rf_q[rt_addr];

  assign wr_addr = RegDst ? rd_addr : rt_addr;
  assign wr_data = MemtoReg ? data_q : aluout_q;

  assign sign_imm    = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_target = {pc_q[WIDTH-1 -: 4], ir_q[25:0], 2'b00};

  assign src_a = ALUSrcA ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    unique case (ALUSrcB)
      2'b00: src_b = b_q;
      2'b01: src_b = WIDTH'(4);
      2'b10: src_b = sign_imm;
      2'b11: src_b = {sign_imm[WIDTH-3:0], 2'b00};
      default: src_b = b_q;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (ALUcontrol)
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b111:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign ZeroFlag = (alu_result == '0);

  always_comb begin
    pc_d = alu_result;
    case (PCSrc)
      2'b01:   pc_d = aluout_q;
      2'b10:   pc_d = jump_target;
      default: pc_d = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (PCEn) begin
        pc_q <= pc_d;
      end
      if (IRWrite) begin
        ir_q <= ReadData;
      end
      data_q   <= ReadData;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= alu_result;
      if (RegWrite && (wr_addr != 5'd0)) begin
        rf_q[wr_addr] <= wr_data;
      end
    end
  end

  assign Adr         = IorD ? aluout_q : pc_q;
  assign WriteData   = b_q;
  assign MemWriteOut = MemWrite;
  assign op          = ir_q[31:26];
  assign funct       = ir_q[5:0];

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Bench acting as controller + memory; an instruction-level MIPS model predicts
// datapath outputs, which a negedge monitor checks from a scoreboard queue.
module tb_mips_multicycle_datapath;

  localparam int unsigned WIDTH = 32;

  logic        clk, reset;
  logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUcontrol;
  logic [31:0] ReadData, Adr, WriteData;
  logic        MemWriteOut, ZeroFlag;
  logic [5:0]  op, funct;

  mips_multicycle_datapath #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUcontrol(ALUcontrol), .PCSrc(PCSrc), .PCEn(PCEn),
    .ReadData(ReadData), .Adr(Adr), .WriteData(WriteData), .MemWriteOut(MemWriteOut),
    .op(op), .funct(funct), .ZeroFlag(ZeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- environment memory ----------------
  logic [31:0] cur_instr;
  logic [31:0] mem_q [256];
  logic        mem_wr [256];

  function automatic logic [31:0] init_val(input logic [7:0] idx);
    return ({24'd0, idx} * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  always_comb begin
    ReadData = cur_instr;
    if (IorD) ReadData = mem_wr[Adr[9:2]] ? mem_q[Adr[9:2]] : init_val(Adr[9:2]);
  end

  always @(posedge clk) begin
    if (reset && MemWriteOut) begin
      mem_q[Adr[9:2]]  <= WriteData;
      mem_wr[Adr[9:2]] <= 1'b1;
    end
  end

  // ---------------- scoreboard + monitor ----------------
  localparam int KAdr = 0, KWd = 1, KZero = 2, KOp = 3, KFunct = 4, KMwo = 5;
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;
  chk_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input int kind, input logic [31:0] exp, input string nm);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = nm;
    sbq.push_back(c);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      KAdr:    return Adr;
      KWd:     return WriteData;
      KZero:   return {31'd0, ZeroFlag};
      KOp:     return {26'd0, op};
      KFunct:  return {26'd0, funct};
      default: return {31'd0, MemWriteOut};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = sbq.pop_front();
      act = observe(c.kind);
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", c.name, act, c.exp, $time);
      end
    end
  end

  // ---------------- reference model (ISA level) ----------------
  logic [31:0] m_pc;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];
  logic        m_wr  [256];

  function automatic logic [31:0] sext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] r_op(input logic [5:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b011;
    endcase
  endfunction

  task automatic m_write(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] o, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {o, 5'(rs), 5'(rt), imm};
  endfunction

  // ---------------- controller emulation ----------------
  task automatic idle();
    IorD = 0; MemWrite = 0; IRWrite = 0; RegDst = 0; MemtoReg = 0; RegWrite = 0;
    ALUSrcA = 0; ALUSrcB = 2'b00; ALUcontrol = 3'b010; PCSrc = 2'b00; PCEn = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic [5:0]  o, f;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, res, addr, target;
    o  = ins[31:26]; f = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a  = m_reg[rs];  b = m_reg[rt];

    cur_instr = ins;
    IRWrite = 1; ALUSrcB = 2'b01; ALUcontrol = 3'b010; PCEn = 1;
    push(KAdr, m_pc, "fetch_adr");
    tick();
    m_pc = m_pc + 32'd4;

    ALUSrcB = 2'b11; ALUcontrol = 3'b010;
    push(KOp, {26'd0, o}, "decode_op");
    push(KFunct, {26'd0, f}, "decode_funct");
    tick();
    target = m_pc + (sext(ins[15:0]) << 2);

    case (o)
      6'h00: begin
        ALUSrcA = 1; ALUcontrol = alu_code(f);
        res = r_op(f, a, b);
        push(KWd, b, "rtype_b");
        push(KZero, {31'd0, res == 32'd0}, "rtype_zero");
        tick();
        RegDst = 1; RegWrite = 1;
        tick();
        m_write(rd, res);
      end
      6'h08: begin
        ALUSrcA = 1; ALUSrcB = 2'b10;
        res = a + sext(ins[15:0]);
        push(KWd, b, "addi_b");
        push(KZero, {31'd0, res == 32'd0}, "addi_zero");
        tick();
        RegWrite = 1;
        tick();
        m_write(rt, res);
      end
      6'h23, 6'h2b: begin
        ALUSrcA = 1; ALUSrcB = 2'b10;
        addr = a + sext(ins[15:0]);
        push(KWd, b, "mem_exec_b");
        tick();
        IorD = 1;
        push(KAdr, addr, "mem_adr");
        if (o == 6'h2b) begin
          MemWrite = 1;
          push(KWd, b, "sw_data");
          push(KMwo, 32'd1, "sw_mwo");
          tick();
          m_mem[addr[9:2]] = b;
          m_wr[addr[9:2]]  = 1'b1;
        end else begin
          tick();
          MemtoReg = 1; RegWrite = 1;
          tick();
          m_write(rt, m_wr[addr[9:2]] ? m_mem[addr[9:2]] : init_val(addr[9:2]));
        end
      end
      6'h04: begin
        ALUSrcA = 1; ALUcontrol = 3'b110; PCSrc = 2'b01; PCEn = (a == b);
        push(KZero, {31'd0, a == b}, "beq_zero");
        tick();
        if (a == b) m_pc = target;
      end
      default: begin
        PCSrc = 2'b10; PCEn = 1;
        push(KWd, b, "j_b");
        tick();
        m_pc = {m_pc[31:28], ins[25:0], 2'b00};
      end
    endcase
  endtask

  function automatic logic [31:0] rand_ins();
    int          k, rs, rt, rd;
    logic [5:0]  fl [5];
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2a;
    k  = $urandom_range(0, 6);
    rs = $urandom_range(0, 15);
    rt = $urandom_range(0, 15);
    rd = $urandom_range(0, 15);
    case (k)
      0:       return r_ins(rs, rt, rd, fl[$urandom_range(0, 4)]);
      2:       return i_ins(6'h23, rs, rt, 16'($urandom));
      3:       return i_ins(6'h2b, rs, rt, 16'($urandom));
      4: begin
        if ($urandom_range(0, 2) == 0) rt = rs;
        return i_ins(6'h04, rs, rt, 16'($urandom_range(0, 64)) - 16'd32);
      end
      5:       return {6'h02, 26'($urandom)};
      default: return i_ins(6'h08, rs, rt, 16'($urandom));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 0;
    cur_instr = 32'h2008_0005;
    idle();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 32'd0;
      m_wr[i]  = 1'b0;
    end

    // Held in reset with an active fetch: nothing may move.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      IRWrite = 1; ALUSrcB = 2'b01; PCEn = 1; RegWrite = 1;
      push(KAdr, 32'h0, "rst_adr");
      push(KOp, 32'h0, "rst_op");
      push(KWd, 32'h0, "rst_wd");
    end
    idle();
    reset = 1;

    run_instr(32'h2008_0005);                    // addi $8,$0,5
    run_instr(r_ins(8, 8, 9, 6'h20));            // add  $9,$8,$8
    run_instr(i_ins(6'h2b, 0, 9, 16'h0100));     // sw   $9,0x100($0)
    run_instr(i_ins(6'h08, 0, 0, 16'h0007));     // addi $0,$0,7
    run_instr(i_ins(6'h2b, 0, 0, 16'h0104));     // sw   $0,0x104($0)
    run_instr(i_ins(6'h08, 0, 9, 16'h0005));     // addi $9,$0,5
    run_instr(i_ins(6'h04, 8, 9, 16'h0003));     // beq  $8,$9,+3
    run_instr(32'h0800_0010);                    // j    0x40
    run_instr(i_ins(6'h08, 0, 10, 16'hFFFF));    // addi $10,$0,-1
    run_instr(i_ins(6'h08, 0, 11, 16'h0001));    // addi $11,$0,1
    run_instr(r_ins(10, 11, 12, 6'h2a));         // slt  $12,$10,$11
    run_instr(r_ins(10, 11, 13, 6'h20));         // add  $13,$10,$11 -> 0
    run_instr(r_ins(10, 11, 14, 6'h3f));         // unsupported code -> 0
    run_instr(i_ins(6'h23, 0, 15, 16'h0100));    // lw   $15,0x100($0)
    run_instr(i_ins(6'h2b, 0, 12, 16'h0108));
    run_instr(i_ins(6'h2b, 0, 13, 16'h010C));
    run_instr(i_ins(6'h2b, 0, 14, 16'h0110));
    run_instr(i_ins(6'h2b, 0, 15, 16'h0114));

    for (int n = 0; n < 200; n++) run_instr(rand_ins());
    for (int r = 1; r < 16; r++) run_instr(i_ins(6'h2b, 0, r, 16'(r * 4)));

    // Asynchronous reset mid-run clears state without waiting for an edge.
    ALUSrcA = 1; RegWrite = 1; PCEn = 1;
    reset = 0;
    #1;
    total++;
    if (Adr !== 32'h0) begin
      bad++;
      $display("FAIL midrst_adr_now: got %h want %h", Adr, 32'h0);
    end
    total++;
    if (op !== 6'h0) begin
      bad++;
      $display("FAIL midrst_op_now: got %h want %h", op, 6'h0);
    end
    total++;
    if (funct !== 6'h0) begin
      bad++;
      $display("FAIL midrst_funct_now: got %h want %h", funct, 6'h0);
    end
    total++;
    if (WriteData !== 32'h0) begin
      bad++;
      $display("FAIL midrst_wd_now: got %h want %h", WriteData, 32'h0);
    end
    push(KAdr, 32'h0, "midrst_adr");
    push(KOp, 32'h0, "midrst_op");
    push(KFunct, 32'h0, "midrst_funct");
    push(KWd, 32'h0, "midrst_wd");
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (total < 12) begin
      $display("FAIL check_count: got %0d want at least 12", total);
    end else if (bad != 0) begin
      $display("FAIL: %0d of %0d checks failed", bad, total);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
